// File: rtl/sg13g2_tbus_arbiter.sv
// Round-robin owner select for a shared tri-state bus driving active-low TE_B enables; grant 1 cycle after REQ.
// Break-before-make: TURN_CYC released cycles between owners; tenure capped at MAX_HOLD only while others wait.
module sg13g2_tbus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic [N_REQ-1:0] TE_B,
  output logic             BUS_BUSY,
  output logic             HOLD_EXP
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [PW-1:0]   win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] own_oh;
  logic            others;

  // Lowest set index above ptr wins; otherwise wrap to the lowest index at or below ptr.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[i] && PW'(i) <= ptr) win_idx = PW'(i);
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (REQ[i] && PW'(i) > ptr) win_idx = PW'(i);
    end
  end

  assign win_oh = N_REQ'(1) << win_idx;
  assign own_oh = N_REQ'(1) << ptr;
  assign others = |(REQ & ~own_oh);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      GNT      <= '0;
      TE_B     <= '1;
      BUS_BUSY <= 1'b0;
      HOLD_EXP <= 1'b0;
      ptr      <= PW'(N_REQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      HOLD_EXP <= 1'b0;
      case (state)
        IDLE: begin
          if (|REQ) begin
            state    <= DRIVE;
            GNT      <= win_oh;
            TE_B     <= ~win_oh;
            ptr      <= win_idx;
            hold_cnt <= '0;
            BUS_BUSY <= 1'b1;
          end
        end
        DRIVE: begin
          if (!REQ[ptr] || (hold_cnt == HOLD_LAST && others)) begin
            state    <= TURN;
            GNT      <= '0;
            TE_B     <= '1;
            turn_cnt <= '0;
            HOLD_EXP <= REQ[ptr];
          end else if (hold_cnt == HOLD_LAST) begin
            // Sole requester keeps the bus; restart its tenure window.
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN: begin
          if (turn_cnt == TURN_LAST) begin
            if (|REQ) begin
              state    <= DRIVE;
              GNT      <= win_oh;
              TE_B     <= ~win_oh;
              ptr      <= win_idx;
              hold_cnt <= '0;
            end else begin
              state    <= IDLE;
              BUS_BUSY <= 1'b0;
            end
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sg13g2_tbus_arbiter.sv
// Directed vectors plus multi-cycle sequences for the tri-state bus arbiter; two instances (TURN_CYC=1 and 3).
module tb_sg13g2_tbus_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       busy;
    logic       hexp;
  } vec_t;

  logic       CLK;
  logic       RESET, rst2;
  logic [3:0] REQ, req2;
  logic [3:0] GNT, TE_B, gnt2, te_b2;
  logic       BUS_BUSY, HOLD_EXP, busy2, hexp2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] prev_gnt, prev_gnt2, req_edge, req2_edge;

  sg13g2_tbus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYC(1)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .TE_B(TE_B),
    .BUS_BUSY(BUS_BUSY), .HOLD_EXP(HOLD_EXP)
  );

  sg13g2_tbus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYC(3)) dut3 (
    .CLK(CLK), .RESET(rst2), .REQ(req2), .GNT(gnt2), .TE_B(te_b2),
    .BUS_BUSY(busy2), .HOLD_EXP(hexp2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inv(input string tag, input logic [3:0] g, input logic [3:0] t,
                           input logic [3:0] pg, input logic [3:0] re);
    chk({tag, "_onehot"}, 32'($countones(g) <= 1), 32'd1);
    chk({tag, "_teb_inv"}, 32'(t ^ g), 32'hF);
    chk({tag, "_gnt_req"}, 32'(g & ~pg & ~re), 32'd0);
    if (pg != 4'b0 && g != 4'b0) chk({tag, "_no_swap"}, 32'(g), 32'(pg));
  endtask

  task automatic tick();
    req_edge  = REQ;
    req2_edge = req2;
    prev_gnt  = GNT;
    prev_gnt2 = gnt2;
    @(posedge CLK);
    #1;
    check_inv("a", GNT, TE_B, prev_gnt, req_edge);
    check_inv("b", gnt2, te_b2, prev_gnt2, req2_edge);
  endtask

  vec_t vt[$];

  initial begin
    RESET = 1'b1; REQ = 4'b0; rst2 = 1'b1; req2 = 4'b0;
    prev_gnt = 4'b0; prev_gnt2 = 4'b0; req_edge = 4'b0; req2_edge = 4'b0;

    // reset, single owner 0 for 4 cycles, release, idle
    vt.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});
    // owner 1 releases as 3 and 0 rise: 3 wins after TURN
    vt.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b1001, 4'b0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b1001, 4'b1000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b1001, 4'b1000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0});
    // owner 2, reset mid-DRIVE, re-grant of 2
    vt.push_back('{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0});
    vt.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0});
    vt.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0});

    foreach (vt[k]) begin
      logic [3:0] exp_teb;
      exp_teb = ~vt[k].gnt;
      RESET = vt[k].rst;
      REQ   = vt[k].req;
      tick();
      chk($sformatf("v%0d_gnt", k), 32'(GNT), 32'(vt[k].gnt));
      chk($sformatf("v%0d_te_b", k), 32'(TE_B), 32'(exp_teb));
      chk($sformatf("v%0d_busy", k), 32'(BUS_BUSY), 32'(vt[k].busy));
      chk($sformatf("v%0d_hexp", k), 32'(HOLD_EXP), 32'(vt[k].hexp));
    end

    // lone requester 2 keeps the bus through counter reloads
    for (int c = 0; c < 40; c++) begin
      REQ = 4'b0100;
      tick();
      chk($sformatf("solo%0d_gnt", c), 32'(GNT), 32'h4);
      chk($sformatf("solo%0d_hexp", c), 32'(HOLD_EXP), 32'h0);
    end
    REQ = 4'b0000;
    tick();
    tick();
    chk("solo_idle_busy", 32'(BUS_BUSY), 32'h0);

    // all requesting from reset: 0,1,2,3,0 with 16-cycle tenures
    RESET = 1'b1; REQ = 4'b1111;
    tick();
    RESET = 1'b0;
    for (int o = 0; o < 5; o++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (o % 4);
      for (int c = 0; c < 16; c++) begin
        tick();
        chk($sformatf("rr%0d_%0d_gnt", o, c), 32'(GNT), 32'(exp_g));
        chk($sformatf("rr%0d_%0d_hexp", o, c), 32'(HOLD_EXP), 32'h0);
      end
      if (o < 4) begin
        tick();
        chk($sformatf("rr%0d_turn_gnt", o), 32'(GNT), 32'h0);
        chk($sformatf("rr%0d_turn_teb", o), 32'(TE_B), 32'hF);
        chk($sformatf("rr%0d_turn_hexp", o), 32'(HOLD_EXP), 32'h1);
        chk($sformatf("rr%0d_turn_busy", o), 32'(BUS_BUSY), 32'h1);
      end
    end
    REQ = 4'b0000;
    tick();
    tick();

    // TURN_CYC=3 instance: three released cycles between owner 0 and owner 1
    rst2 = 1'b0; req2 = 4'b0011;
    for (int c = 0; c < 16; c++) begin
      tick();
      chk($sformatf("t3_own0_%0d", c), 32'(gnt2), 32'h1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("t3_gap%0d_gnt", c), 32'(gnt2), 32'h0);
      chk($sformatf("t3_gap%0d_teb", c), 32'(te_b2), 32'hF);
      chk($sformatf("t3_gap%0d_busy", c), 32'(busy2), 32'h1);
      chk($sformatf("t3_gap%0d_hexp", c), 32'(hexp2), (c == 0) ? 32'h1 : 32'h0);
    end
    tick();
    chk("t3_own1_gnt", 32'(gnt2), 32'h2);

    // random REQ soak; invariants are checked every tick
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) REQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req2 = 4'($urandom_range(0, 15));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
